// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  // One queued accelerator result: destination register and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_entry_t;

  // NORMAL: core has priority. DRAIN: one forced FIFO slot after starvation.
  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// Synchronous FIFO of writeback entries. All slots and a valid mask are
// exported so the parent can build the pending-register vector.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  wb_entry_t                  push_entry,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output wb_entry_t [DEPTH-1:0]      entries,
  output logic [DEPTH-1:0]           valid_mask
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          do_push, do_pop;
  logic [AW-1:0] offs;

  // A push into a full FIFO is only allowed when the head leaves in the same cycle.
  assign do_push = push && (!full_q || pop);
  assign do_pop  = pop && (count_q != '0);

  // Next-state for storage, pointers, occupancy and the registered full flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == (AW+1)'(DEPTH));
  end

  // Storage is not reset; only pointers and occupancy are.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    offs       = '0;
    valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs          = AW'(i) - rd_ptr_q;
      valid_mask[i] = ({1'b0, offs} < count_q);
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign entries = mem_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: core writeback passes straight through,
// accelerator results queue in a FIFO and drain into idle write slots, with
// a forced drain slot after prolonged starvation.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   core_we,
  input  logic [REG_ADDR_W-1:0]  core_rd,
  input  logic [XLEN-1:0]        core_data,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [REG_ADDR_W-1:0]  acc_rd,
  input  logic [XLEN-1:0]        acc_data,
  input  logic [REG_ADDR_W-1:0]  dec_rs1,
  input  logic [REG_ADDR_W-1:0]  dec_rs2,
  input  logic [REG_ADDR_W-1:0]  dec_rd,
  output logic                   dec_hazard,
  output logic                   core_stall,
  output logic                   rf_write_reg,
  output logic [REG_ADDR_W-1:0]  rf_rd,
  output logic [XLEN-1:0]        rf_data_in,
  output logic [31:0]            pending,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
  logic                  core_eff;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t             push_entry, fifo_head;
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic [DEPTH-1:0]      fifo_valid;

  // Writes to x0 are architecturally void, so they never claim the port.
  assign core_eff   = core_we && (core_rd != '0);
  assign acc_ready  = reset_n && !fifo_full;
  assign fifo_push  = acc_valid && acc_ready && (acc_rd != '0);
  assign push_entry = '{rd: acc_rd, data: XLEN_DEF'(acc_data)};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .push_entry (push_entry),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .entries    (fifo_entries),
    .valid_mask (fifo_valid)
  );

  // Write-port mux: core first; otherwise drain the FIFO head (never during reset).
  always_comb begin
    rf_write_reg = 1'b0;
    rf_rd        = '0;
    rf_data_in   = '0;
    fifo_pop     = 1'b0;
    core_stall   = reset_n && (state_q == DRAIN);
    if (core_eff) begin
      rf_write_reg = 1'b1;
      rf_rd        = core_rd;
      rf_data_in   = core_data;
    end else if (reset_n && !fifo_empty) begin
      rf_write_reg = 1'b1;
      rf_rd        = fifo_head.rd;
      rf_data_in   = XLEN'(fifo_head.data);
      fifo_pop     = 1'b1;
    end
  end

  // Starvation FSM: count cycles the core blocks a non-empty FIFO, then stall once.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      NORMAL: begin
        if (fifo_pop || fifo_empty) begin
          starve_cnt_d = '0;
        end else if (core_eff) begin
          if (starve_cnt_q == CW'(STARVE_LIMIT - 1)) begin
            state_d      = DRAIN;
            starve_cnt_d = '0;
          end else begin
            starve_cnt_d = starve_cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        state_d      = NORMAL;
        starve_cnt_d = '0;
      end
      default: begin
        state_d      = NORMAL;
        starve_cnt_d = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Pending scoreboard: one bit per register targeted by any live FIFO slot.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) begin
        pending[fifo_entries[i].rd] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  assign dec_hazard = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd];

endmodule
